// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BE_W           = 4;
    localparam int unsigned STARVE_MAX_DEF = 4;

    localparam logic [ADDR_W-1:0] WORD_MASK = 32'hfffffffc;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    // Counter width able to hold 0..max (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive instruction-port denials.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = STARVE_MAX_DEF,
    localparam int unsigned CW = cnt_width(MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

    assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-ported word memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_byteen,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_byteen,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CW = cnt_width(STARVE_MAX);

    logic          at_max;
    logic          starve_inc;
    logic          starve_clr;
    logic [CW-1:0] starve_count_unused;
    logic          d_write;
    owner_t        owner;
    logic          owner_wr;

    // Grant selection and memory command; everything held at zero during reset.
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        d_write    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = '0;
        mem_re     = 1'b0;
        if (reset) begin
            i_gnt   = i_req && (!d_req || at_max);
            d_gnt   = d_req && !i_gnt;
            d_write = d_gnt && (d_byteen != '0);
            if (i_gnt) begin
                mem_addr = i_addr & WORD_MASK;
                mem_re   = 1'b1;
            end else if (d_gnt) begin
                mem_addr = d_addr & WORD_MASK;
                if (d_write) begin
                    mem_wdata  = d_wdata;
                    mem_byteen = d_byteen;
                end else begin
                    mem_re = 1'b1;
                end
            end
        end
    end

    assign starve_inc = i_req && !i_gnt;
    assign starve_clr = !starve_inc;

    arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .count  (starve_count_unused),
        .at_max (at_max)
    );

    // Owner of the access whose response appears next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner    <= OWN_NONE;
            owner_wr <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            owner    <= i_gnt ? OWN_INST : (d_gnt ? OWN_DATA : OWN_NONE);
            owner_wr <= d_write;
            i_rvalid <= i_gnt;
            d_rvalid <= d_gnt;
        end
    end

    assign i_rdata = (owner == OWN_INST) ? mem_rdata : '0;
    assign d_rdata = ((owner == OWN_DATA) && !owner_wr) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by random traffic.
module tb_mem_arbiter;

    localparam int unsigned SMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_byteen = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_re;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_byteen   (d_byteen),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        ig;
        logic        dg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        re;
    } gnt_exp_t;

    typedef struct {
        int          due;
        logic        iv;
        logic        dv;
        logic [31:0] id;
        logic [31:0] dd;
    } rsp_exp_t;

    gnt_exp_t    gnt_q[$];
    rsp_exp_t    rsp_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          run = 1'b0;
    int          starve = 0;
    logic        lig = 1'b0;
    logic        ldg = 1'b0;
    logic [31:0] pend_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and record what the arbiter must do about it.
    task automatic drive(input logic rst_v, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] rdn);
        gnt_exp_t g;
        rsp_exp_t r;
        logic     wr;
        @(posedge clk);
        #1;
        reset     = rst_v;
        mem_rdata = pend_rd;
        pend_rd   = rdn;
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wdata = wd; d_byteen = be;
        g = '{due: cyc, ig: 1'b0, dg: 1'b0, addr: '0, wdata: '0, be: '0, re: 1'b0};
        if (!rst_v) begin
            rsp_q.delete();
            starve = 0;
        end else begin
            g.ig = ir && (!dr || starve == int'(SMAX));
            g.dg = dr && !g.ig;
            wr   = g.dg && (be != 4'd0);
            if (g.ig) g.addr = {ia[31:2], 2'b00};
            if (g.dg) g.addr = {da[31:2], 2'b00};
            g.wdata = wr ? wd : 32'd0;
            g.be    = wr ? be : 4'd0;
            g.re    = g.ig || (g.dg && !wr);
            if (ir && !g.ig) starve = (starve < int'(SMAX)) ? starve + 1 : starve;
            else starve = 0;
            if (g.ig) begin
                r = '{due: cyc + 1, iv: 1'b1, dv: 1'b0, id: rdn, dd: 32'd0};
                rsp_q.push_back(r);
            end else if (g.dg) begin
                r = '{due: cyc + 1, iv: 1'b0, dv: 1'b1, id: 32'd0, dd: wr ? 32'd0 : rdn};
                rsp_q.push_back(r);
            end
        end
        lig = g.ig;
        ldg = g.dg;
        gnt_q.push_back(g);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, '0, 1'b0, '0, '0, 4'd0, $urandom);
    endtask

    // Monitor: compare every presented output against the scoreboard heads.
    always @(negedge clk) begin
        gnt_exp_t g;
        rsp_exp_t r;
        if (run) begin
            if (gnt_q.size() > 0 && gnt_q[0].due == cyc) begin
                g = gnt_q.pop_front();
                chk("i_gnt", 32'(i_gnt), 32'(g.ig));
                chk("d_gnt", 32'(d_gnt), 32'(g.dg));
                chk("mem_addr", mem_addr, g.addr);
                chk("mem_wdata", mem_wdata, g.wdata);
                chk("mem_byteen", 32'(mem_byteen), 32'(g.be));
                chk("mem_re", 32'(mem_re), 32'(g.re));
            end
            r = '{due: cyc, iv: 1'b0, dv: 1'b0, id: '0, dd: '0};
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) r = rsp_q.pop_front();
            chk("i_rvalid", 32'(i_rvalid), 32'(r.iv));
            chk("d_rvalid", 32'(d_rvalid), 32'(r.dv));
            chk("i_rdata", i_rdata, r.id);
            chk("d_rdata", d_rdata, r.dd);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ir, dr;
        logic [31:0] ia, da, wd;
        logic [3:0]  be;
        run = 1'b1;
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 32'h5, 4'hf, '0);
        drive(1'b0, 1'b1, 32'h10, 1'b0, '0, '0, 4'd0, '0);
        // Single instruction read, then a data write whose grant overlaps the read response.
        drive(1'b1, 1'b1, 32'h3004, 1'b0, '0, '0, 4'd0, 32'h2402000a);
        drive(1'b1, 1'b0, '0, 1'b1, 32'h0006, 32'h12340000, 4'b1100, 32'hdeadbeef);
        idle(1);
        // Both held: data wins until the instruction side has been denied SMAX times.
        for (int k = 0; k < 12; k++)
            drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h203, '0, 4'd0, $urandom);
        idle(1);
        drive(1'b1, 1'b1, 32'h40, 1'b0, '0, '0, 4'd0, $urandom);
        drive(1'b1, 1'b0, '0, 1'b1, 32'h80, '0, 4'd0, $urandom);
        drive(1'b1, 1'b1, 32'h44, 1'b0, '0, '0, 4'd0, $urandom);
        idle(1);
        // Instruction request withdrawn before winning clears the starve history.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 32'h50, 1'b1, 32'h90, 32'h1, 4'h1, $urandom);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, '0, 1'b1, 32'h94, 32'h2, 4'h3, $urandom);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 32'h54, 1'b1, 32'h98, '0, 4'd0, $urandom);
        idle(1);
        // Reset lands in the response cycle of a read.
        drive(1'b1, 1'b1, 32'h60, 1'b0, '0, '0, 4'd0, $urandom);
        drive(1'b0, 1'b1, 32'h64, 1'b1, 32'h68, '0, 4'd0, $urandom);
        drive(1'b0, 1'b1, 32'h64, 1'b1, 32'h68, 32'h7, 4'hf, $urandom);
        idle(3);
        // Random traffic; pending requests mostly held stable until granted.
        ir = 0; dr = 0; ia = 0; da = 0; wd = 0; be = 0;
        for (int k = 0; k < 500; k++) begin
            if (!(ir && !lig) || $urandom_range(0, 7) == 0) begin
                ir = 1'($urandom_range(0, 1));
                ia = $urandom;
            end
            if (!(dr && !ldg) || $urandom_range(0, 7) == 0) begin
                dr = 1'($urandom_range(0, 1));
                da = $urandom;
                wd = $urandom;
                be = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            end
            drive(1'b1, ir, ia, dr, da, wd, be, $urandom);
        end
        idle(2);
        @(posedge clk);
        #1;
        chk("rsp_drain", 32'(rsp_q.size()), 32'd0);
        chk("gnt_drain", 32'(gnt_q.size()), 32'd0);
        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive instruction-port denials after which instruction wins.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have ports i_req in 1, i_addr in 32: instruction-fetch request and byte address.
REQ-005 SHALL have ports i_gnt out 1, i_rvalid out 1, i_rdata out 32: instruction grant, response valid, read word.
REQ-006 SHALL have ports d_req in 1, d_addr in 32, d_wdata in 32, d_byteen in 4: data request; d_byteen==0 means read, nonzero means write.
REQ-007 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out 32: data grant, response valid, read word.
REQ-008 SHALL have ports mem_addr out 32, mem_wdata out 32, mem_byteen out 4, mem_re out 1, mem_rdata in 32: single-ported word memory; read data valid one cycle after mem_re.

Function
REQ-009 SHALL grant at most one requester per cycle; grant is combinational from current requests and registered state.
REQ-010 SHALL grant data over instruction by default when both request.
REQ-011 SHALL grant instruction instead when starve count == STARVE_MAX and i_req==1.
REQ-012 SHALL increment the saturating starve count each cycle i_req==1 and i_gnt==0, and clear it on i_gnt or when i_req==0.
REQ-013 SHALL, in a grant cycle, drive mem_addr = granted address & 32'hfffffffc; other cycles mem_addr = 0.
REQ-014 SHALL, on data-write grant, drive mem_byteen = d_byteen and mem_wdata = d_wdata, mem_re = 0; otherwise mem_byteen = 0 and mem_wdata = 0.
REQ-015 SHALL, on any read grant (instruction, or data with d_byteen==0), drive mem_re = 1.
REQ-016 SHALL register the grant owner (NONE/INST/DATA) and pulse the owner's rvalid exactly one cycle after grant.
REQ-017 SHALL route mem_rdata to the owner's rdata during that rvalid cycle; the non-owner rdata SHALL be 0.
REQ-018 SHALL pulse d_rvalid for writes too (completion ack), with d_rdata = 0.
REQ-019 SHALL support back-to-back grants every cycle (throughput 1 access/cycle, latency 1 cycle).
REQ-020 SHALL require requesters to hold req/addr/data stable until granted; a request dropped before grant is ignored without error.
REQ-021 SHALL leave outputs unaffected by requests arriving in the same cycle as an rvalid for a different owner (response and new grant coexist).

Reset
REQ-022 SHALL, while reset==0, force owner = NONE, starve count = 0, and all grant, rvalid, mem_re, mem_byteen outputs 0, all data/address outputs 0.
REQ-023 SHALL discard any in-flight response when reset asserts mid-access; no rvalid SHALL follow reset release.
REQ-024 SHALL accept grants in the first rising edge after reset deasserts.

Structure
REQ-025 SHALL place owner enum (NONE/INST/DATA), STARVE_MAX default, and word-align mask constant 32'hfffffffc in package mem_arb_pkg.
REQ-026 SHALL implement the saturating starve counter as sub-module arb_starve_cnt (inputs: inc, clr; output: count, at_max).
REQ-027 SHALL contain no memory array; storage stays external.

Verification
REQ-028 Only i_req, i_addr=0x3004, mem_rdata=0x2402000a -> i_gnt same cycle, mem_addr=0x3004, mem_re=1; next cycle i_rvalid=1, i_rdata=0x2402000a.
REQ-029 d_req write d_addr=0x0006, d_byteen=4'b1100, d_wdata=0x12340000 -> d_gnt, mem_addr=0x0004, mem_byteen=4'b1100, mem_re=0; next cycle d_rvalid=1, d_rdata=0.
REQ-030 i_req and d_req held continuously -> d_gnt cycles 1-4, i_gnt cycle 5, starve count returns to 0, pattern repeats.
REQ-031 Alternating single-cycle grants INST, DATA, INST -> rvalid owner sequence INST, DATA, INST, each one cycle late, no overlap.
REQ-032 reset=0 asserted in the cycle after a read grant -> no i_rvalid/d_rvalid at any edge after release; all outputs 0 during reset.
REQ-033 i_req dropped before grant while d_req active -> starve count clears, no i_gnt, data grants unaffected.
